// File: rtl/bdi_pkg.sv
// Shared BDI definitions: encoding codes, compressed sizes, candidate order
// and the selector FSM state type. Also used by the compressor and decompressor.
package bdi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] ENC_ZEROS  = 4'd0;
    localparam logic [3:0] ENC_REP8   = 4'd1;
    localparam logic [3:0] ENC_B8D1   = 4'd2;
    localparam logic [3:0] ENC_B4D1   = 4'd3;
    localparam logic [3:0] ENC_B8D2   = 4'd4;
    localparam logic [3:0] ENC_B2D1   = 4'd5;
    localparam logic [3:0] ENC_B4D2   = 4'd6;
    localparam logic [3:0] ENC_B8D4   = 4'd7;
    localparam logic [3:0] ENC_UNCOMP = 4'd15;

    localparam logic [5:0] SIZE_UNCOMP = 6'd32;

    localparam int NUM_CAND = 8;

    // Candidates are tried from index 0 upward; the first one that fits wins.
    localparam logic [NUM_CAND-1:0][3:0] CAND_CODE = {
        ENC_B8D4, ENC_B4D2, ENC_B2D1, ENC_B8D2,
        ENC_B4D1, ENC_B8D1, ENC_REP8, ENC_ZEROS
    };

    localparam logic [NUM_CAND-1:0][5:0] CAND_SIZE = {
        6'd24, 6'd20, 6'd18, 6'd16,
        6'd12, 6'd12, 6'd8,  6'd1
    };

    function automatic logic [3:0] cand_code(input logic [2:0] k);
        return CAND_CODE[k];
    endfunction

    function automatic logic [5:0] cand_size(input logic [2:0] k);
        return CAND_SIZE[k];
    endfunction

endpackage

// File: rtl/bdi_delta_check.sv
// Base-delta fit test for one BxDy candidate: every BASE_BYTES-wide element,
// minus element 0 (modulo the element width), must fit in a signed
// DELTA_BYTES-wide value.
module bdi_delta_check #(
    parameter int BASE_BYTES  = 8,
    parameter int DELTA_BYTES = 1
) (
    input  logic [255:0] line,
    output logic         pass
);

    localparam int EW       = 8 * BASE_BYTES;
    localparam int DW       = 8 * DELTA_BYTES;
    localparam int NUM_ELEM = 256 / EW;

    logic [EW-1:0]  diff;
    logic [EW-DW:0] upper;

    // A delta fits when the bits above the delta's sign bit are a pure sign extension.
    always_comb begin
        pass  = 1'b1;
        diff  = '0;
        upper = '0;
        for (int i = 1; i < NUM_ELEM; i++) begin
            diff  = line[i*EW +: EW] - line[EW-1:0];
            upper = diff[EW-1:DW-1];
            if ((upper != '0) && (upper != '1)) begin
                pass = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bdi_encoding_selector.sv
// BDI encoding selector: captures a 256-bit line, tries one candidate
// encoding per cycle in fixed order and reports the first that fits.
module bdi_encoding_selector
    import bdi_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_line,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_line,
    output logic [3:0]   out_enc,
    output logic [5:0]   out_size
);

    state_t       state;
    state_t       state_next;
    logic [2:0]   k;
    logic         ready_en;
    logic [255:0] line_q;
    logic [3:0]   enc_q;
    logic [5:0]   size_q;
    logic [7:0]   cand_pass;
    logic         cur_pass;
    logic         accept;

    assign accept = in_valid && in_ready;

    assign cand_pass[0] = (line_q == '0);
    assign cand_pass[1] = (line_q[63:0] == line_q[127:64]) &&
                          (line_q[63:0] == line_q[191:128]) &&
                          (line_q[63:0] == line_q[255:192]);

    bdi_delta_check #(.BASE_BYTES(8), .DELTA_BYTES(1)) u_b8d1 (.line(line_q), .pass(cand_pass[2]));
    bdi_delta_check #(.BASE_BYTES(4), .DELTA_BYTES(1)) u_b4d1 (.line(line_q), .pass(cand_pass[3]));
    bdi_delta_check #(.BASE_BYTES(8), .DELTA_BYTES(2)) u_b8d2 (.line(line_q), .pass(cand_pass[4]));
    bdi_delta_check #(.BASE_BYTES(2), .DELTA_BYTES(1)) u_b2d1 (.line(line_q), .pass(cand_pass[5]));
    bdi_delta_check #(.BASE_BYTES(4), .DELTA_BYTES(2)) u_b4d2 (.line(line_q), .pass(cand_pass[6]));
    bdi_delta_check #(.BASE_BYTES(8), .DELTA_BYTES(4)) u_b8d4 (.line(line_q), .pass(cand_pass[7]));

    assign cur_pass = cand_pass[k];

    // Holds in_ready low until the first clock edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept -> evaluate candidates -> hold result until consumed.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_EVAL;
            ST_EVAL: if (cur_pass || (k == 3'd7)) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Line capture, candidate index and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
            k      <= '0;
            enc_q  <= '0;
            size_q <= '0;
        end else if (accept) begin
            line_q <= in_line;
            k      <= '0;
        end else if (state == ST_EVAL) begin
            if (cur_pass) begin
                enc_q  <= cand_code(k);
                size_q <= cand_size(k);
            end else if (k == 3'd7) begin
                enc_q  <= ENC_UNCOMP;
                size_q <= SIZE_UNCOMP;
            end else begin
                k <= k + 3'd1;
            end
        end
    end

    assign in_ready  = (state == ST_IDLE) && ready_en;
    assign out_valid = (state == ST_DONE);
    assign out_line  = line_q;
    assign out_enc   = enc_q;
    assign out_size  = size_q;

endmodule
